// File: rtl/gaussian_blur_stream.sv
// gaussian_blur_stream: streaming separable 5-tap Gaussian blur with replicate borders and valid/ready on both sides
module gaussian_blur_stream #(
  parameter int WIDTH  = 128,
  parameter int HEIGHT = 128,
  parameter int PIX_W  = 8,
  parameter int COEF_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [COEF_W-1:0] cfg_w0,
  input  logic [COEF_W-1:0] cfg_w1,
  input  logic [COEF_W-1:0] cfg_w2,
  input  logic [4:0]        cfg_shift,
  input  logic [PIX_W-1:0]  in_pixel,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [PIX_W-1:0]  out_pixel,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic              done
);
  localparam int ACC_W = PIX_W + COEF_W + 3;
  localparam int RW = ACC_W + 32;
  localparam int CW = $clog2(WIDTH + 2);
  localparam int XW = $clog2(WIDTH);
  localparam int YW = $clog2(HEIGHT + 3);
  localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, FLUSH = 2'd2, DONE = 2'd3;
  localparam logic [PIX_W-1:0] PMAX = '1;

  logic [1:0] state;
  logic [COEF_W-1:0] k0, k1, k2;
  logic [4:0] sh;
  logic [CW-1:0] col;
  logic [YW-1:0] row;
  logic [PIX_W-1:0] sr [5];
  logic t0_v;
  logic [XW-1:0] t0_col;
  logic [YW-1:0] t0_row;
  logic s1_v;
  logic [XW-1:0] s1_col;
  logic [YW-1:0] s1_row;
  logic [PIX_W-1:0] s1_h;
  logic s2_v, s2_last;
  logic [ACC_W-1:0] s2_sum;
  logic [PIX_W-1:0] lb [4][WIDTH];
  logic adv, take, gen, push, row_end;
  logic [PIX_W-1:0] h_in;

  function automatic logic [ACC_W-1:0] tap5(input logic [PIX_W-1:0] p0, p1, p2, p3, p4);
    return ACC_W'(k0) * (ACC_W'(p0) + ACC_W'(p4)) + ACC_W'(k1) * (ACC_W'(p1) + ACC_W'(p3)) + ACC_W'(k2) * ACC_W'(p2);
  endfunction

  function automatic logic [PIX_W-1:0] rs(input logic [ACC_W-1:0] a);
    logic [RW-1:0] t;
    t = (RW'(a) + (sh == 5'd0 ? '0 : RW'(1) << (sh - 5'd1))) >> sh;
    return t > RW'(PMAX) ? PMAX : t[PIX_W-1:0];
  endfunction

  // Each row is pushed as WIDTH real pixels plus two internal replicate pushes; rows HEIGHT and HEIGHT+1 are generated from the line buffers.
  assign adv = !(out_valid && !out_ready);
  assign row_end = col == CW'(WIDTH + 1);
  assign in_ready = state == RUN && adv && col < CW'(WIDTH);
  assign take = in_valid && in_ready;
  assign gen = adv && ((state == RUN && col >= CW'(WIDTH)) || (state == FLUSH && row != YW'(HEIGHT + 2)));
  assign push = take || gen;
  assign busy = state == RUN || state == FLUSH;
  assign done = state == DONE;
  assign h_in = s1_row >= YW'(HEIGHT) ? lb[0][s1_col] : s1_h;

  // Frame sequencing, raster position counters and the horizontal tap window.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      k0 <= COEF_W'(1);
      k1 <= COEF_W'(4);
      k2 <= COEF_W'(6);
      sh <= 5'd4;
      col <= '0;
      row <= '0;
      sr <= '{default: '0};
      t0_v <= 1'b0;
      t0_col <= '0;
      t0_row <= '0;
    end else begin
      if (state == IDLE && start) begin
        state <= RUN;
        k0 <= cfg_w0;
        k1 <= cfg_w1;
        k2 <= cfg_w2;
        sh <= cfg_shift;
        col <= '0;
        row <= '0;
      end
      if (take && row == YW'(HEIGHT - 1) && col == CW'(WIDTH - 1)) state <= FLUSH;
      if (state == FLUSH && out_valid && out_ready && out_last) state <= DONE;
      if (state == DONE) state <= IDLE;
      if (adv) begin
        t0_v <= push && col >= CW'(2);
        t0_col <= XW'(col - CW'(2));
        t0_row <= row;
      end
      if (push) begin
        col <= row_end ? (row >= YW'(HEIGHT - 1) ? CW'(2) : '0) : col + CW'(1);
        row <= row_end ? row + YW'(1) : row;
        if (col == '0) sr <= '{in_pixel, in_pixel, in_pixel, in_pixel, in_pixel};
        else sr <= '{sr[1], sr[2], sr[3], sr[4], col < CW'(WIDTH) ? in_pixel : sr[4]};
      end
    end

  // Row pass, column pass and output register; everything freezes while the output is back-pressured.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      s1_v <= 1'b0;
      s1_col <= '0;
      s1_row <= '0;
      s1_h <= '0;
      s2_v <= 1'b0;
      s2_last <= 1'b0;
      s2_sum <= '0;
      out_valid <= 1'b0;
      out_pixel <= '0;
      out_last <= 1'b0;
    end else if (adv) begin
      s1_v <= t0_v;
      s1_col <= t0_col;
      s1_row <= t0_row;
      s1_h <= rs(tap5(sr[0], sr[1], sr[2], sr[3], sr[4]));
      s2_v <= s1_v && s1_row >= YW'(2);
      s2_last <= s1_row == YW'(HEIGHT + 1) && s1_col == XW'(WIDTH - 1);
      s2_sum <= tap5(lb[3][s1_col], lb[2][s1_col], lb[1][s1_col], lb[0][s1_col], h_in);
      out_valid <= s2_v;
      out_last <= s2_v && s2_last;
      if (s2_v) out_pixel <= rs(s2_sum);
    end

  // Line buffers hold the previous four row-pass results per column; row 0 fills all four to clamp the top edge.
  always_ff @(posedge clk)
    if (adv && s1_v) begin
      lb[0][s1_col] <= h_in;
      lb[1][s1_col] <= s1_row == '0 ? h_in : lb[0][s1_col];
      lb[2][s1_col] <= s1_row == '0 ? h_in : lb[1][s1_col];
      lb[3][s1_col] <= s1_row == '0 ? h_in : lb[2][s1_col];
    end
endmodule

// File: tb/tb_gaussian_blur_stream.sv
// tb_gaussian_blur_stream: directed and randomized frames on 8x8 and 16x16 instances against a plain-arithmetic blur model
module tb_gaussian_blur_stream;
  logic clk = 0, rst = 1, start = 0, sel = 0;
  logic [7:0] w0 = 1, w1 = 4, w2 = 6;
  logic [4:0] shift = 4;
  logic [7:0] in_pixel = 0;
  logic in_valid = 0, out_ready = 1;
  logic a_in_ready, a_out_valid, a_out_last, a_busy, a_done;
  logic b_in_ready, b_out_valid, b_out_last, b_busy, b_done;
  logic [7:0] a_out_pixel, b_out_pixel;
  logic i_ready, o_valid, o_last, o_busy, o_done;
  logic [7:0] o_pixel;
  int total = 0, bad = 0;
  int img[16][16], ex[16][16], got[16][16];

  always #5 clk = ~clk;

  gaussian_blur_stream #(.WIDTH(8), .HEIGHT(8), .PIX_W(8), .COEF_W(8)) ua (
    .clk(clk), .rst(rst), .start(start && !sel), .cfg_w0(w0), .cfg_w1(w1), .cfg_w2(w2),
    .cfg_shift(shift), .in_pixel(in_pixel), .in_valid(in_valid && !sel), .in_ready(a_in_ready),
    .out_pixel(a_out_pixel), .out_valid(a_out_valid), .out_ready(out_ready), .out_last(a_out_last),
    .busy(a_busy), .done(a_done));

  gaussian_blur_stream #(.WIDTH(16), .HEIGHT(16), .PIX_W(8), .COEF_W(8)) ub (
    .clk(clk), .rst(rst), .start(start && sel), .cfg_w0(w0), .cfg_w1(w1), .cfg_w2(w2),
    .cfg_shift(shift), .in_pixel(in_pixel), .in_valid(in_valid && sel), .in_ready(b_in_ready),
    .out_pixel(b_out_pixel), .out_valid(b_out_valid), .out_ready(out_ready), .out_last(b_out_last),
    .busy(b_busy), .done(b_done));

  assign i_ready = sel ? b_in_ready : a_in_ready;
  assign o_valid = sel ? b_out_valid : a_out_valid;
  assign o_last = sel ? b_out_last : a_out_last;
  assign o_busy = sel ? b_busy : a_busy;
  assign o_done = sel ? b_done : a_done;
  assign o_pixel = sel ? b_out_pixel : a_out_pixel;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int rnd(longint x, int s);
    longint t;
    t = s == 0 ? x : (x + (longint'(1) << (s - 1))) >> s;
    return t > 255 ? 255 : int'(t);
  endfunction

  function automatic int cl(int v, int n);
    return v < 0 ? 0 : (v > n - 1 ? n - 1 : v);
  endfunction

  task automatic model(input int w, h, k0, k1, k2, s);
    int hr[16][16];
    int k[5];
    longint acc;
    k = '{k0, k1, k2, k1, k0};
    for (int r = 0; r < h; r++)
      for (int c = 0; c < w; c++) begin
        acc = 0;
        for (int d = 0; d < 5; d++) acc += longint'(k[d] * img[r][cl(c + d - 2, w)]);
        hr[r][c] = rnd(acc, s);
      end
    for (int r = 0; r < h; r++)
      for (int c = 0; c < w; c++) begin
        acc = 0;
        for (int d = 0; d < 5; d++) acc += longint'(k[d] * hr[cl(r + d - 2, h)][c]);
        ex[r][c] = rnd(acc, s);
      end
  endtask

  task automatic run_frame(input string nm, input int w, h, k0, k1, k2, s, input bit rin, rout, mid);
    int idx = 0, oidx = 0, n = w * h, it = 0, hs22 = -1, fov = -1, dones = 0, tail = 0;
    bit hold = 0;
    logic [7:0] hp;
    logic hl;
    model(w, h, k0, k1, k2, s);
    @(negedge clk);
    w0 = 8'(k0); w1 = 8'(k1); w2 = 8'(k2); shift = 5'(s);
    start = 1;
    @(negedge clk);
    start = 0;
    while (tail < 6 && it < 20000) begin
      in_valid = idx < n && (!rin || $urandom_range(3) != 0);
      in_pixel = 0;
      if (idx < n) in_pixel = 8'(img[idx / w][idx % w]);
      out_ready = !rout || $urandom_range(1) == 1;
      start = mid && idx == 20;
      if (mid && idx == 20) begin
        w0 = 9; w1 = 9; w2 = 9; shift = 0;
      end
      #3;
      if (hold) begin
        chk({nm, " hold valid"}, 32'(o_valid), 1);
        chk({nm, " hold pixel"}, 32'(o_pixel), 32'(hp));
        chk({nm, " hold last"}, 32'(o_last), 32'(hl));
      end
      hold = o_valid && !out_ready;
      hp = o_pixel;
      hl = o_last;
      if (o_valid && out_ready) begin
        if (oidx < n) begin
          chk({nm, " pixel"}, 32'(o_pixel), ex[oidx / w][oidx % w]);
          chk({nm, " last"}, 32'(o_last), 32'(oidx == n - 1));
          got[oidx / w][oidx % w] = int'(o_pixel);
        end else chk({nm, " surplus output"}, oidx, n - 1);
        if (fov < 0) fov = it;
        oidx++;
      end
      if (in_valid && i_ready) begin
        if (idx == 2 * w + 2) hs22 = it;
        idx++;
      end
      if (o_done) dones++;
      if (oidx >= n) tail++;
      @(negedge clk);
      it++;
    end
    in_valid = 0;
    start = 0;
    out_ready = 1;
    chk({nm, " output count"}, oidx, n);
    chk({nm, " done pulses"}, dones, 1);
    chk({nm, " busy after"}, 32'(o_busy), 0);
    // (2,2) is accepted at edge hs22; out (0,0) must be visible after edge hs22+3, i.e. sampled in iteration hs22+4.
    if (!rin && !rout) chk({nm, " latency"}, fov - 1 - hs22, 3);
  endtask

  initial begin
    int acc;
    repeat (3) @(negedge clk);
    chk("reset out_valid", 32'(o_valid), 0);
    chk("reset in_ready", 32'(i_ready), 0);
    chk("reset out_pixel", 32'(o_pixel), 0);
    chk("reset out_last", 32'(o_last), 0);
    chk("reset busy", 32'(o_busy), 0);
    chk("reset done", 32'(o_done), 0);
    rst = 0;

    for (int r = 0; r < 8; r++) for (int c = 0; c < 8; c++) img[r][c] = 100;
    run_frame("const100", 8, 8, 1, 4, 6, 4, 0, 0, 0);

    for (int r = 0; r < 8; r++) for (int c = 0; c < 8; c++) img[r][c] = (r == 4 && c == 4) ? 255 : 0;
    run_frame("impulse", 8, 8, 1, 4, 6, 4, 0, 0, 0);
    chk("impulse (4,4)", got[4][4], 36);
    chk("impulse (3,3)", got[3][3], 16);
    chk("impulse (4,3)", got[4][3], 24);

    for (int r = 0; r < 8; r++) for (int c = 0; c < 8; c++) img[r][c] = c == 0 ? 200 : 0;
    run_frame("edge", 8, 8, 1, 4, 6, 4, 0, 1, 0);
    for (int r = 0; r < 8; r++) begin
      chk("edge col0", got[r][0], 138);
      chk("edge col1", got[r][1], 63);
      chk("edge col2", got[r][2], 13);
    end

    for (int r = 0; r < 8; r++) for (int c = 0; c < 8; c++) img[r][c] = 255;
    run_frame("saturate", 8, 8, 4, 4, 4, 2, 0, 0, 0);

    for (int r = 0; r < 8; r++) for (int c = 0; c < 8; c++) img[r][c] = $urandom_range(255);
    run_frame("randkernel", 8, 8, $urandom_range(255), $urandom_range(255), $urandom_range(255), $urandom_range(31), 0, 0, 0);

    sel = 1;
    for (int r = 0; r < 16; r++) for (int c = 0; c < 16; c++) img[r][c] = $urandom_range(255);
    run_frame("random16", 16, 16, 1, 4, 6, 4, 1, 1, 0);
    sel = 0;

    @(negedge clk);
    w0 = 1; w1 = 4; w2 = 6; shift = 4;
    start = 1;
    @(negedge clk);
    start = 0;
    acc = 0;
    in_pixel = 50;
    out_ready = 1;
    in_valid = 1;
    for (int i = 0; i < 200 && acc < 30; i++) begin
      #3;
      if (i_ready) acc++;
      @(negedge clk);
    end
    in_valid = 0;
    chk("midreset accepted", acc, 30);
    rst = 1;
    #1;
    chk("midreset out_valid", 32'(o_valid), 0);
    chk("midreset out_pixel", 32'(o_pixel), 0);
    chk("midreset in_ready", 32'(i_ready), 0);
    chk("midreset busy", 32'(o_busy), 0);
    @(negedge clk);
    rst = 0;
    for (int r = 0; r < 8; r++) for (int c = 0; c < 8; c++) img[r][c] = 50;
    run_frame("after reset", 8, 8, 1, 4, 6, 4, 0, 0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/gaussian_blur_stream.md
Name: gaussian_blur_stream

Overview:
- Next-generation separable 5-tap Gaussian blur.
- Takes a raster-order pixel stream with valid/ready handshakes on both sides, instead of reading a ROM at a fixed rate.
- Parametrised in image size and pixel width. Symmetric kernel and shift are loaded at run time on start.
- Output frame is the same size as the input, using replicate (clamp) border handling. Sits between any pixel source (ROM reader, camera capture) and the DoG/octave stages.

Parameters:
- WIDTH, 128, pixels per row (>= 5)
- HEIGHT, 128, rows per frame (>= 5)
- PIX_W, 8, pixel bit width, unsigned
- COEF_W, 8, kernel coefficient bit width, unsigned

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse; begins a frame and latches cfg_* (ignored unless IDLE)
- cfg_w0  in  COEF_W  outer taps (k0 = k4)
- cfg_w1  in  COEF_W  inner taps (k1 = k3)
- cfg_w2  in  COEF_W  centre tap
- cfg_shift  in  5  normalisation right-shift, 0..31
- in_pixel  in  PIX_W  input pixel, raster order
- in_valid  in  1  input pixel valid
- in_ready  out  1  block can accept input
- out_pixel  out  PIX_W  blurred pixel, raster order
- out_valid  out  1  output pixel valid
- out_ready  in  1  sink accepts output
- out_last  out  1  high with the final pixel (H-1, W-1)
- busy  out  1  frame in progress
- done  out  1  one-cycle pulse after the final pixel is accepted

Behaviour:
- Reset (async, any time, including mid-frame):
  - state returns to IDLE; all counters, line buffers' valid tracking and pipeline valids are cleared.
  - in_ready=0, out_valid=0, out_pixel=0, out_last=0, busy=0, done=0.
  - Latched kernel resets to 1,4,6 with shift 4.
- States: IDLE -> RUN -> FLUSH -> DONE -> IDLE.
  - IDLE: in_ready=0. On start, latch cfg_*, clear counters, busy=1, go to RUN.
  - RUN: in_ready=1 unless the pipeline is stalled. Accepts exactly WIDTH*HEIGHT pixels; goes to FLUSH after the last one is accepted.
  - FLUSH: in_ready=0. The block generates the remaining outputs internally, using clamped taps from the line buffers.
  - DONE: entered when the final output handshake occurs (out_valid & out_ready & out_last). done=1 for exactly one cycle in DONE, busy drops in the same cycle, then return to IDLE.
  - start during RUN, FLUSH or DONE is ignored.
  - in_valid outside RUN is ignored.
- Row pass:
  - Formula: h = k0*p[c-2] + k1*p[c-1] + k2*p[c] + k1*p[c+1] + k0*p[c+2].
  - Column indices are clamped to 0..WIDTH-1.
  - Rounding: r = (h + (shift>0 ? 1<<(shift-1) : 0)) >> shift, then saturate to 2^PIX_W-1.
  - Accumulator width: PIX_W + COEF_W + 3. No overflow is permitted.
- Column pass:
  - Same formula, rounding and saturation over rows r-2..r+2.
  - Row indices are clamped to 0..HEIGHT-1.
  - Four row-result line buffers of WIDTH x PIX_W.
- Ordering and latency:
  - Output (r,c) depends on input (min(r+2,H-1), min(c+2,W-1)).
  - With out_ready held high, out_valid for (r,c) asserts exactly 3 cycles after that input's handshake. In FLUSH, outputs follow at 1 per cycle.
- Backpressure:
  - When out_valid=1 and out_ready=0, out_pixel, out_last and out_valid hold stable.
  - The whole pipeline freezes and in_ready=0 in the same cycle. No pixel is dropped or duplicated.
- Output count is exactly WIDTH*HEIGHT per frame.
- Kernel changes on cfg_* mid-frame have no effect until the next start.

Test Plan:
- Constant 100 frame, 8x8, kernel 1,4,6 shift 4, out_ready=1 -> 64 outputs all 100; out_last on the 64th; done pulses once; busy low afterwards.
- 8x8 zeros with 255 at (4,4), kernel 1,4,6 shift 4 -> out (4,4)=36, (3,3)=16, (4,3)=24 (per-axis tap values 64/96/16/...); all pixels beyond distance 2 are 0.
- Edge clamp: 8x8 frame where column 0 = 200 and all else 0, kernel 1,4,6 shift 4 -> out (r,0)=138, (r,1)=63, (r,2)=13, (r,3..7)=0 for every r.
- Saturation: constant 255, kernel 4,4,4 shift 2 -> every output 255, no wrap.
- Random out_ready (50%) and random in_valid gaps on a 16x16 random frame -> output stream is bit-exact with the golden model; out_pixel stable whenever out_valid & !out_ready.
- Assert rst for 1 cycle after 30 inputs, then start a new 8x8 constant-50 frame -> all outputs are cleared immediately; new frame yields 64 x 50; start pulses issued mid-frame are ignored.
